// File: rtl/serial_ones_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_ones_counter_pkg
// Purpose  : State encodings and the ceil-log2 width helper used by the
//            serial ones counter.
// Revision : 1.0 - initial release
// ============================================================================
package serial_ones_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Number of bits needed to encode values 0 .. value-1.
    function automatic int f_clog2(input int value);
        int r_bits;
        int r_val;
        r_bits = 0;
        r_val  = value - 1;
        while (r_val > 0) begin
            r_bits = r_bits + 1;
            r_val  = r_val >> 1;
        end
        return r_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_ones_counter_ripple_inc.sv
`default_nettype none
// ============================================================================
// Module   : ripple_inc
// Purpose  : CW-bit ripple incrementer built from one-bit full-adder cells
//            (b tied low, inc as carry-in, final carry-out dropped).
// Revision : 1.0 - initial release
// ============================================================================
module ripple_inc #(
    parameter int CW = 5
) (
    input  logic [CW-1:0] a,
    input  logic          inc,
    output logic [CW-1:0] y
);

    logic [CW-1:0] w_carry;

    assign w_carry[0] = inc;

    for (genvar i = 0; i < CW; i++) begin : g_cell
        logic w_b;
        assign w_b  = 1'b0;
        assign y[i] = a[i] ^ w_b ^ w_carry[i];
        // The top cell's carry-out has nowhere to go: the count never exceeds WIDTH.
        if (i < CW - 1) begin : g_carry
            assign w_carry[i+1] = (a[i] & w_b) | (w_carry[i] & (a[i] ^ w_b));
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_ones_counter.sv
`default_nettype none
// ============================================================================
// Module   : serial_ones_counter
// Purpose  : Serial population counter, one bit per clock LSB->MSB.
//            Optional macro SERIAL_ONES_COUNTER_EARLY_EXIT_EN ends the scan
//            once no set bits remain in the shift register.
// Revision : 1.0 - initial release
// ============================================================================
module serial_ones_counter
    import serial_ones_counter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CW    = f_clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count
);

    localparam int            c_IW       = f_clog2(WIDTH);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(WIDTH - 1);
    localparam logic [c_IW-1:0] c_IDX_ONE  = c_IW'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [c_IW-1:0]  r_idx;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_inc;
    logic             w_accept;
    logic             w_last;

    ripple_inc #(
        .CW (CW)
    ) u_inc (
        .a   (r_count),
        .inc (r_shreg[0]),
        .y   (w_count_inc)
    );

`ifdef SERIAL_ONES_COUNTER_EARLY_EXIT_EN
    // Post-shift register empty means no further bit can change the count.
    assign w_last = (r_idx == c_LAST_IDX) || (r_shreg[WIDTH-1:1] == '0);
`else
    assign w_last = (r_idx == c_LAST_IDX);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_shreg <= data_in;
                r_idx   <= '0;
                r_count <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_shreg <= r_shreg >> 1;
                r_idx   <= r_idx + c_IDX_ONE;
                r_count <= w_count_inc;
            end
        end
    end

    // Outputs decode state/count registers only; nothing reaches them from inputs.
    assign busy  = (r_state == ST_SHIFT);
    assign done  = (r_state == ST_DONE);
    assign count = r_count;

endmodule
`default_nettype wire

// File: doc/serial_ones_counter.md
# serial_ones_counter

Sequential population counter: accepts a WIDTH-bit word on a start strobe, scans it one bit per clock from LSB to MSB, and accumulates the number of 1s. The accumulate step uses a ripple incrementer built from one-bit full-adder cells. The block feeds the bit-counting datapath's result register and display logic. It is the serial, area-lean alternative to the combinational adder-tree counter.

## Interface
Parameters:
- WIDTH, 16, input word width (≥ 2)
- CW, $clog2(WIDTH+1), count width (derived; 5 for WIDTH=16)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-high
- start  input  1  request; sampled only in IDLE or DONE
- data_in  input  WIDTH  word to count; sampled on accepted start
- busy  output  1  high while scanning
- done  output  1  one-cycle pulse when count is final
- count  output  CW  ones count; valid from done until next accepted start

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. On start=1, the accept actions are:
  - shreg←data_in, count←0, idx←0
  - go to SHIFT.
- SHIFT: busy=1, once per cycle:
  - count←count+shreg[0], via ripple incrementer, no saturation needed (max = WIDTH fits CW)
  - shreg←shreg>>1, idx←idx+1
  - When idx==WIDTH-1 (last bit processed), go to DONE.
- DONE: done=1, busy=0, count holds.
  - Next state is IDLE, unless start=1, which is accepted exactly as in IDLE (back-to-back).
- start while in SHIFT: ignored, no queueing; data_in don't-care.
- count holds its final value through IDLE until the next accepted start clears it.
- Reset (any state, any time): state=IDLE, busy=0, done=0, count=0, shreg=0, idx=0. An in-flight scan is discarded; no done pulse.

## Timing
- Start accepted at edge T → SHIFT during cycles T+1…T+WIDTH → done=1 during cycle T+WIDTH+1 (without early exit).
- All outputs are registered; no combinational path from inputs to outputs.
- Throughput: one word per WIDTH+1 cycles with back-to-back starts.
- idx width: $clog2(WIDTH); wraps never occur because exit is forced at WIDTH-1.

## Configuration
- Macro: SERIAL_ONES_COUNTER_EARLY_EXIT_EN.
- Defined: in SHIFT, if the post-shift shreg is zero (no 1s remain), go to DONE on the same edge as the normal transition would.
  - Latency becomes (index of highest set bit)+2 cycles from accept to done.
  - data_in=0 gives done at T+2.
  - The count value is identical to the non-early-exit result.
- Undefined: fixed WIDTH-cycle scan; latency independent of data.

## Structure
- Shared package/include: state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the count-width helper (ceil-log2).
- One sub-module: ripple_inc.
  - Parameter CW; inputs a[CW-1:0] and inc (1 bit); output y[CW-1:0].
  - Built as a chain of one-bit full-adder cells, with inc as the carry-in and b tied to 0.
  - Final carry-out is dropped.
- Top contains the FSM, shreg, idx and count registers.

## Test plan
- Reset then start with data_in=16'hFFFF at T → busy T+1…T+16, done pulse at T+17, count=16; done low at T+18.
- data_in=16'h8001 → count=2, done at T+17 in both builds; data_in=16'h0003 with EARLY_EXIT_EN → count=2, done at T+3; without it, done at T+17.
- data_in=16'h0000 → count=0; done at T+17 (T+2 with EARLY_EXIT_EN).
- Start with 16'hA5A5, reassert start with 16'hFFFF at T+5 → second start ignored, count=8 at T+17.
- Start held high continuously with 16'h00F0, then 16'h0F0F → done pulses at T+17 and T+34; count 4 then 8, cleared to 0 at the second accept.
- Assert rst at T+6 of a 16'hFFFF scan → immediately busy=0, count=0, no done pulse; a fresh start then completes normally.
